// File: rtl/rob_2w.sv
`default_nettype none
// ============================================================================
// Module      : rob_2w
// Description : Two-wide reorder buffer. Allocates up to two renamed
//               instructions per cycle, records completion from two
//               writeback ports and retires up to two completed instructions
//               per cycle in program order.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_2w #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  // rename-side allocation
  input  logic              alloc_valid_1,
  input  logic              alloc_valid_2,
  input  logic              has_rd_1,
  input  logic              has_rd_2,
  input  logic [AREG_W-1:0] rd_1,
  input  logic [AREG_W-1:0] rd_2,
  input  logic [PREG_W-1:0] pd_1,
  input  logic [PREG_W-1:0] pd_2,
  input  logic [PREG_W-1:0] old_pd_1,
  input  logic [PREG_W-1:0] old_pd_2,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx_1,
  output logic [IDX_W-1:0]  alloc_idx_2,
  // writeback completion
  input  logic              cmp_valid_a,
  input  logic              cmp_valid_b,
  input  logic [IDX_W-1:0]  cmp_idx_a,
  input  logic [IDX_W-1:0]  cmp_idx_b,
  // retirement
  output logic              ret_valid_1,
  output logic              ret_valid_2,
  output logic              ret_has_rd_1,
  output logic              ret_has_rd_2,
  output logic [AREG_W-1:0] ret_rd_1,
  output logic [AREG_W-1:0] ret_rd_2,
  output logic [PREG_W-1:0] ret_pd_1,
  output logic [PREG_W-1:0] ret_pd_2,
  output logic [PREG_W-1:0] ret_old_pd_1,
  output logic [PREG_W-1:0] ret_old_pd_2,
  // occupancy
  output logic [IDX_W:0]    count,
  output logic              empty
);

  localparam logic [IDX_W:0]   c_depth = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   c_zero  = '0;
  localparam logic [IDX_W:0]   c_one   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   c_two   = (IDX_W+1)'(2);
  localparam logic [IDX_W-1:0] c_inc   = IDX_W'(1);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]    r_head;
  logic [IDX_W:0]    r_tail;

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [DEPTH-1:0]  r_has_rd;
  logic [AREG_W-1:0] r_rd     [DEPTH];
  logic [PREG_W-1:0] r_pd     [DEPTH];
  logic [PREG_W-1:0] r_old_pd [DEPTH];

  logic [IDX_W-1:0]  w_head0;
  logic [IDX_W-1:0]  w_head1;
  logic [IDX_W-1:0]  w_tail0;
  logic [IDX_W-1:0]  w_tail1;
  logic [IDX_W:0]    w_free;
  logic              w_acc1;
  logic              w_acc2;
  logic              w_ret1;
  logic              w_ret2;
  logic [IDX_W:0]    w_n_acc;
  logic [IDX_W:0]    w_n_ret;

  assign w_head0 = r_head[IDX_W-1:0];
  assign w_head1 = w_head0 + c_inc;
  assign w_tail0 = r_tail[IDX_W-1:0];
  assign w_tail1 = w_tail0 + c_inc;

  // Occupancy is the pointer distance; the wrap bit makes DEPTH representable.
  assign count = r_tail - r_head;
  assign empty = (count == c_zero);
  assign w_free = c_depth - count;

  // Readiness uses start-of-cycle occupancy only; same-cycle retires do not help.
  assign alloc_ready = (w_free >= c_two);
  assign alloc_idx_1 = w_tail0;
  assign alloc_idx_2 = w_tail1;

  // Slot 2 is never taken on its own, keeping allocation contiguous.
  assign w_acc1 = alloc_valid_1 & alloc_ready;
  assign w_acc2 = w_acc1 & alloc_valid_2;

  // Retire strictly in order: slot 2 depends on slot 1 retiring.
  assign w_ret1 = r_valid[w_head0] & r_done[w_head0];
  assign w_ret2 = w_ret1 & r_valid[w_head1] & r_done[w_head1];

  assign w_n_acc = w_acc2 ? c_two : (w_acc1 ? c_one : c_zero);
  assign w_n_ret = w_ret2 ? c_two : (w_ret1 ? c_one : c_zero);

  // Pointer advance by the number of accepted and retired entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= c_zero;
      r_tail <= c_zero;
    end else begin
      r_head <= r_head + w_n_ret;
      r_tail <= r_tail + w_n_acc;
    end
  end

  // Entry status: completions first, then retire clears, then allocation sets.
  // Allocated slots are never live and retired slots are always live, so the
  // three groups touch disjoint entries except for harmless completion overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (cmp_valid_a && r_valid[cmp_idx_a]) r_done[cmp_idx_a] <= 1'b1;
      if (cmp_valid_b && r_valid[cmp_idx_b]) r_done[cmp_idx_b] <= 1'b1;
      if (w_ret1) begin
        r_valid[w_head0] <= 1'b0;
        r_done[w_head0]  <= 1'b0;
      end
      if (w_ret2) begin
        r_valid[w_head1] <= 1'b0;
        r_done[w_head1]  <= 1'b0;
      end
      if (w_acc1) begin
        r_valid[w_tail0] <= 1'b1;
        r_done[w_tail0]  <= 1'b0;
      end
      if (w_acc2) begin
        r_valid[w_tail1] <= 1'b1;
        r_done[w_tail1]  <= 1'b0;
      end
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (w_acc1) begin
      r_has_rd[w_tail0] <= has_rd_1;
      r_rd[w_tail0]     <= rd_1;
      r_pd[w_tail0]     <= pd_1;
      r_old_pd[w_tail0] <= old_pd_1;
    end
    if (w_acc2) begin
      r_has_rd[w_tail1] <= has_rd_2;
      r_rd[w_tail1]     <= rd_2;
      r_pd[w_tail1]     <= pd_2;
      r_old_pd[w_tail1] <= old_pd_2;
    end
  end

  // Registered one-cycle retire pulses carrying the retired entry fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_valid_1  <= 1'b0;
      ret_valid_2  <= 1'b0;
      ret_has_rd_1 <= 1'b0;
      ret_has_rd_2 <= 1'b0;
      ret_rd_1     <= '0;
      ret_rd_2     <= '0;
      ret_pd_1     <= '0;
      ret_pd_2     <= '0;
      ret_old_pd_1 <= '0;
      ret_old_pd_2 <= '0;
    end else begin
      ret_valid_1  <= w_ret1;
      ret_valid_2  <= w_ret2;
      ret_has_rd_1 <= w_ret1 & r_has_rd[w_head0];
      ret_has_rd_2 <= w_ret2 & r_has_rd[w_head1];
      ret_rd_1     <= r_rd[w_head0];
      ret_rd_2     <= r_rd[w_head1];
      ret_pd_1     <= r_pd[w_head0];
      ret_pd_2     <= r_pd[w_head1];
      ret_old_pd_1 <= r_old_pd[w_head0];
      ret_old_pd_2 <= r_old_pd[w_head1];
    end
  end

endmodule
`default_nettype wire

// File: doc/rob_2w.md
Name: rob_2w

Overview:
- Two-wide, in-order-retire reorder buffer that sits directly downstream of the rename stage.
- Each cycle it accepts up to two renamed instructions and returns a ROB tag for each. It records completion reported by up to two writeback ports, and retires up to two completed instructions per cycle in program order.
- On retire it emits the architectural destination, the new physical destination, and the previous physical mapping. The previous mapping is returned to the free pool.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, minimum 4.
- IDX_W, 4, log2(DEPTH), width of ROB tags.
- PREG_W, 6, physical register index width (64 physical regs).
- AREG_W, 5, architectural register index width (32 arch regs).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid_1  in  1  rename slot 1 presents an instruction.
- alloc_valid_2  in  1  rename slot 2 presents an instruction (younger than slot 1).
- has_rd_1, has_rd_2  in  1 each  instruction writes a destination register.
- rd_1, rd_2  in  AREG_W each  architectural destination.
- pd_1, pd_2  in  PREG_W each  newly allocated physical destination.
- old_pd_1, old_pd_2  in  PREG_W each  previous RAT mapping of rd.
- alloc_ready  out  1  at least 2 free entries this cycle.
- alloc_idx_1, alloc_idx_2  out  IDX_W each  ROB tags assigned to slot 1 and slot 2 (combinational).
- cmp_valid_a, cmp_valid_b  in  1 each  writeback completion strobes.
- cmp_idx_a, cmp_idx_b  in  IDX_W each  tags of the completing instructions.
- ret_valid_1, ret_valid_2  out  1 each  retire pulse for the oldest and second-oldest instruction.
- ret_has_rd_1, ret_has_rd_2  out  1 each  retired instruction had a destination.
- ret_rd_1, ret_rd_2  out  AREG_W each  retired architectural destination.
- ret_pd_1, ret_pd_2  out  PREG_W each  retired physical destination (commit mapping).
- ret_old_pd_1, ret_old_pd_2  out  PREG_W each  physical reg to free; meaningful only when ret_has_rd is 1.
- count  out  IDX_W+1  current occupancy, range 0..DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage and pointers:
  - Circular buffer with head and tail pointers, each IDX_W+1 bits; the MSB is a wrap bit.
  - Per entry: valid, done, has_rd, rd, pd, old_pd.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - head=0, tail=0, count=0; all valid and done bits cleared.
  - All ret_* outputs are 0. alloc_ready=1 (after reset). empty=1.
- Allocation:
  - alloc_ready = (DEPTH - count) >= 2, evaluated on start-of-cycle count. There is no bypass of same-cycle retires.
  - Slot 2 is accepted only if slot 1 is also valid; alloc_valid_2 with alloc_valid_1=0 is ignored entirely.
  - Accepted when alloc_ready=1: slot 1 is written at tail, slot 2 at tail+1. Each written entry gets valid=1, done=0.
  - Tail advances by the number accepted (0/1/2).
  - alloc_idx_1 = tail[IDX_W-1:0]; alloc_idx_2 = tail+1 (mod DEPTH). Both are driven regardless of the valid inputs.
  - When alloc_ready=0, all alloc_valid inputs are dropped; upstream must hold them.
- Completion:
  - cmp_valid_x sets done[cmp_idx_x] on the next edge, only if that entry is valid.
  - A completion to an invalid entry is ignored.
  - Both ports hitting the same tag in one cycle is legal; the result is done=1.
- Retire:
  - Evaluated on start-of-cycle state. A completion arriving in cycle N can retire no earlier than cycle N+1's edge.
  - Slot 1 retires if entry[head] is valid and done.
  - Slot 2 retires only if slot 1 retires and entry[head+1] is valid and done. Retirement is never out of order.
  - Retired entries are cleared (valid=0, done=0) and head advances by the number retired.
  - ret_* outputs are registered one-cycle pulses carrying the retired entry's fields. When ret_valid_x=0, ret_has_rd_x=0 and the other fields are don't-care.
- Occupancy:
  - count_next = count + accepted - retired.
  - Simultaneous allocate and retire of the same count is legal.
  - Pointer wrap from DEPTH-1 to 0 toggles the wrap bit.
  - Full: count == DEPTH. Empty: count == 0, in which case no retire occurs.
- Latency:
  - Allocate at edge N → earliest done at edge N+1 (completion presented in cycle N+1) → earliest ret_valid at edge N+2.

Test Plan:
- Reset mid-run: with 5 entries live, assert rst → count=0, empty=1, ret_valid_1/2=0 immediately, alloc_ready=1; next allocation receives alloc_idx_1=0.
- Two-wide alloc and in-order retire:
  - Alloc {rd=3,pd=33,old=3} and {rd=4,pd=34,old=4} → tags 0,1.
  - Complete tag 1 only → no retire.
  - Then complete tag 0 → the next edge gives ret_valid_1=1 (pd=33, old=3) and ret_valid_2=1 (pd=34, old=4); count returns to 0.
- Full back-pressure: 8 dual allocates with no completions → count=16, alloc_ready=0; a further alloc_valid_1=1 is dropped and tail is unchanged.
- Fill to 15 entries → alloc_ready=0 (only 1 free).
- Wrap-around:
  - Run 20 alloc/complete/retire pairs → tags wrap 15→0.
  - Retire order matches allocation order; ret_pd values equal the pd sequence 32..51.
- Partial retire:
  - Head done, head+1 not done → only ret_valid_1=1.
  - Next cycle complete head+1 → ret_valid_1=1 with that entry's pd.
- Edge cases:
  - alloc_valid_2=1 with alloc_valid_1=0 → no entry written, count unchanged.
  - has_rd=0 entry retires with ret_has_rd_1=0.
  - cmp_valid_a and cmp_valid_b on the same tag → single retire.
